// File: rtl/hier_leaf_pkg.sv
// Shared constants, payload type and width helper for the leaf stream FIFO stage.
package hier_leaf_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned DEPTH_DEFAULT  = 4;
    localparam int unsigned CNT_W_DEFAULT  = 16;

    typedef logic [DATA_W_DEFAULT-1:0] leaf_word_t;

    // Bits needed to hold 0..n inclusive when n is a power of two.
    function automatic int unsigned clog2_plus1(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w + 1;
    endfunction

endpackage

// File: rtl/hier_leaf_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read, no reset.
module hier_leaf_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hier_leaf_stream_fifo.sv
// Leaf datapath stage: circular FIFO between valid/ready streams, with a
// delivered-word counter and a running XOR checksum of delivered words.
module hier_leaf_stream_fifo
    import hier_leaf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [clog2_plus1(DEPTH)-1:0] level,
    output logic [CNT_W-1:0]              word_cnt,
    output logic [DATA_W-1:0]             checksum
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = clog2_plus1(DEPTH);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [DATA_W-1:0] r_checksum;

    logic              w_push;
    logic              w_pop;
    logic              w_we;
    logic [LVL_W-1:0]  w_level_nxt;
    logic [DATA_W-1:0] w_rdata;

    // Handshakes only use registered flags, so no ready/valid pass-through.
    assign w_push = in_valid && r_in_ready;
    assign w_pop  = r_out_valid && out_ready;
    assign w_we   = w_push && rst_n && !flush;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_word_cnt  <= '0;
            r_checksum  <= '0;
        end else if (flush) begin
            // Contents dropped; delivery statistics survive the flush.
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                r_word_cnt <= r_word_cnt + CNT_W'(1);
                r_checksum <= r_checksum ^ w_rdata;
            end
            r_level     <= w_level_nxt;
            r_in_ready  <= (w_level_nxt != LVL_W'(DEPTH));
            r_out_valid <= (w_level_nxt != '0);
        end
    end

    hier_leaf_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = w_rdata;
    assign level     = r_level;
    assign word_cnt  = r_word_cnt;
    assign checksum  = r_checksum;

endmodule

// File: tb/tb_hier_leaf_stream_fifo.sv
// Directed bench for hier_leaf_stream_fifo with a queue-based reference model.
module tb_hier_leaf_stream_fifo;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  level;
    logic [15:0] word_cnt;
    logic [7:0]  checksum;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_q[$];
    logic [15:0] m_cnt = '0;
    logic [7:0]  m_cs  = '0;
    bit          m_rst  = 1'b1;
    bit          m_live = 1'b0;

    hier_leaf_stream_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .word_cnt  (word_cnt),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO queue plus delivery statistics, advanced per edge.
    always @(posedge clk) begin : model
        bit rdy;
        bit vld;
        if (!rst_n) begin
            m_q.delete();
            m_cnt  = '0;
            m_cs   = '0;
            m_rst  = 1'b1;
            m_live = 1'b1;
        end else begin
            rdy = !m_rst && (m_q.size() < DEPTH);
            vld = (m_q.size() > 0);
            if (flush) begin
                m_q.delete();
            end else begin
                if (vld && out_ready) begin
                    m_cs  = m_cs ^ m_q[0];
                    m_cnt = m_cnt + 16'd1;
                    void'(m_q.pop_front());
                end
                if (rdy && in_valid) begin
                    m_q.push_back(in_data);
                end
            end
            m_rst = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready", 32'(in_ready), 32'(!m_rst && (m_q.size() != DEPTH)));
            chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            chk("level", 32'(level), 32'(m_q.size()));
            chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
            chk("checksum", 32'(checksum), 32'(m_cs));
            if (m_q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(m_q[0]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic pop_n(input int n);
        out_ready = 1'b1;
        repeat (n) cyc();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Three pushes with downstream stalled.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("t1_level", 32'(level), 32'd3);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", 32'(out_data), 32'h11);
        chk("t1_word_cnt", 32'(word_cnt), 32'd0);

        // Fill to DEPTH, hold a fifth word, then release one slot.
        push(8'h44);
        chk("t2_full_in_ready", 32'(in_ready), 32'd0);
        chk("t2_full_level", 32'(level), 32'd4);
        in_valid = 1'b1;
        in_data  = 8'h55;
        cyc();
        chk("t2_held_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t2_pop_level", 32'(level), 32'd3);
        chk("t2_pop_in_ready", 32'(in_ready), 32'd1);
        chk("t2_pop_head", 32'(out_data), 32'h22);
        pop_n(3);
        chk("t2_drain_level", 32'(level), 32'd0);
        chk("t2_drain_cnt", 32'(word_cnt), 32'd4);
        chk("t2_drain_cs", 32'(checksum), 32'h44);

        // Continuous stream 1..10; first beat also covers push into empty FIFO.
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 8'h01;
        cyc();
        chk("t4_level", 32'(level), 32'd1);
        chk("t4_out_valid", 32'(out_valid), 32'd1);
        chk("t4_out_data", 32'(out_data), 32'h01);
        chk("t4_word_cnt", 32'(word_cnt), 32'd0);
        for (int k = 2; k <= 10; k++) begin
            in_data = 8'(k);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        chk("t3_word_cnt", 32'(word_cnt), 32'd10);
        chk("t3_checksum", 32'(checksum), 32'h0B);
        chk("t3_level", 32'(level), 32'd0);

        // Flush with level 2 / count 5 alongside a push and a pop.
        do_reset();
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        pop_n(4);
        push(8'h05);
        push(8'h06);
        push(8'h07);
        pop_n(1);
        chk("t5_pre_level", 32'(level), 32'd2);
        chk("t5_pre_cnt", 32'(word_cnt), 32'd5);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        out_ready = 1'b1;
        cyc();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_word_cnt", 32'(word_cnt), 32'd5);
        chk("t5_checksum", 32'(checksum), 32'h01);
        chk("t5_in_ready", 32'(in_ready), 32'd1);

        // Reset asserted mid-stream with three words buffered.
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        chk("t6_pre_level", 32'(level), 32'd3);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_cnt", 32'(word_cnt), 32'd0);
        chk("t6_rst_cs", 32'(checksum), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        cyc();

        // Stream until the counter sits at 0xFFFF, then one more pop wraps it.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) begin
            in_data = 8'(i);
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t6_cnt_ffff", 32'(word_cnt), 32'h0000FFFF);
        chk("t6_wrap_pre_level", 32'(level), 32'd1);
        pop_n(1);
        chk("t6_cnt_wrap", 32'(word_cnt), 32'd0);
        chk("t6_wrap_level", 32'(level), 32'd0);

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hier_leaf_stream_fifo.md
Name: hier_leaf_stream_fifo

Overview:
Leaf-level datapath stage instantiated beneath the generated hierarchy nodes (one per sc9_* leaf). It is the first block in the hierarchy with real storage. It accepts a valid/ready byte stream from the upstream leaf, buffers it in a small circular FIFO, and presents it downstream with a per-stage word counter. It also keeps a running XOR checksum of every word it delivers, so hierarchy-wide tests can confirm that data passes through each level unaltered.

Parameters:
DATA_W, 8, payload width in bits
DEPTH, 4, FIFO entries; must be a power of two, >= 2
CNT_W, 16, width of the delivered-word counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous clear of FIFO contents; counter and checksum are kept
in_valid  in  1  upstream word valid
in_ready  out  1  stage can accept a word
in_data  in  DATA_W  upstream payload
out_valid  out  1  downstream word valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  head-of-FIFO payload
level  out  $clog2(DEPTH)+1  current occupancy
word_cnt  out  CNT_W  number of words delivered (out handshakes)
checksum  out  DATA_W  XOR of all delivered words

Behaviour:
- Reset (rst_n=0 at a clk edge): wr_ptr=rd_ptr=0, level=0, out_valid=0, in_ready=0 for that cycle, word_cnt=0, checksum=0. out_data is don't-care but is driven from mem[rd_ptr]; mem itself is not reset.
- In the first cycle after reset release, in_ready=1.
- Handshake: push when in_valid&&in_ready; pop when out_valid&&out_ready.
- in_ready = (level != DEPTH) and not in reset. It is registered-derived and combinationally independent of out_ready, so there is no pass-through when full.
- out_valid = (level != 0). out_data = mem[rd_ptr]. Latency from push to out_valid is 1 cycle; there is no fall-through in the same cycle.
- Simultaneous push and pop:
  - Non-empty, not full: both occur, level unchanged.
  - Empty: only the push happens, because out_valid=0.
  - Full: only the pop happens, because in_ready=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. level is tracked separately, so full and empty are distinguishable.
- On each pop: word_cnt <= word_cnt+1, wrapping modulo 2^CNT_W with no saturation. checksum <= checksum ^ out_data.
- flush=1: pointers and level go to 0 next cycle, and any push/pop in that same cycle is discarded (no count or checksum update). word_cnt and checksum are retained.
- Reset during traffic: all state clears at that edge and in-flight words are lost. Upstream must re-send.
- in_data is ignored when in_valid=0. Changing in_data while in_valid=1 and in_ready=0 is permitted; the sampled value is whatever is present at the accepting edge.
- No internal state machine beyond the pointer and level registers. Control is fully defined by the rules above.

Decomposition:
- Package hier_leaf_pkg holds:
  - DATA_W_DEFAULT and DEPTH_DEFAULT constants
  - typedef logic [DATA_W_DEFAULT-1:0] leaf_word_t
  - function clog2_plus1 used for the level width
- One sub-module is natural: hier_leaf_fifo_mem, a simple dual-port register array with a write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata), no reset.
- Counter, checksum and pointer logic stay in the top.
- Target size is about 150-220 lines total.

Test Plan:
1. Reset, then push 0x11, 0x22, 0x33 with out_ready=0 -> level=3, out_valid=1, out_data=0x11, word_cnt=0.
2. Push 4 words (DEPTH=4) with out_ready=0 -> in_ready=0 after the 4th push. A 5th word held at 0x55 is not accepted and level stays 4. Raise out_ready for one cycle -> pop, level=3, in_ready=1 next cycle.
3. Stream 10 words 0x01..0x0A with in_valid=out_ready=1 continuously -> output order preserved, pointers wrap twice, word_cnt=10, checksum=0x0B (XOR of 1..10).
4. Empty FIFO with in_valid=1 and out_ready=1 in the same cycle -> no pop that cycle; out_valid=1 next cycle with that word.
5. With level=2 and word_cnt=5, assert flush together with in_valid and out_ready -> next cycle level=0, out_valid=0, word_cnt=5, checksum unchanged.
6. Preset word_cnt to 0xFFFF via 65535 pops, then one more pop -> word_cnt=0x0000. Separately, assert rst_n=0 mid-stream with level=3 -> next cycle level=0, out_valid=0, word_cnt=0, checksum=0.
